// File: rtl/uart_parity_tx.sv
// UART transmitter with one parity bit: start, 8 data bits LSB first, parity, stop.
// All outputs are registered; tx idles high and a frame lasts 11 bit periods.
module uart_parity_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       send,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       parity_out
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        ODD       = (PARITY_ODD != 0);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  data_reg;
    logic        bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            data_reg   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            parity_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (send) begin
                        // parity_out doubles as the parity latch used for the parity bit
                        data_reg   <= data_in;
                        parity_out <= (^data_in) ^ ODD;
                        state      <= START;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= data_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= parity_out;
                            state <= PARITY;
                        end else begin
                            tx      <= data_reg[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        // done lands in the first IDLE cycle, where a new send is accepted
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_parity_tx.sv
// Directed bench for uart_parity_tx with CLKS_PER_BIT=4, even and odd parity instances side by side.
module tb_uart_parity_tx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx_e, busy_e, done_e, par_e;
    logic       tx_o, busy_o, done_o, par_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame_even;   // bit 10 is sent first (start bit)
        logic [10:0] frame_odd;
        logic        par_even;
        logic        par_odd;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    uart_parity_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dut_even (
        .clk(clk), .n_rst(n_rst), .send(send), .data_in(data_in),
        .tx(tx_e), .busy(busy_e), .done(done_e), .parity_out(par_e)
    );

    uart_parity_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .n_rst(n_rst), .send(send), .data_in(data_in),
        .tx(tx_o), .busy(busy_o), .done(done_o), .parity_out(par_o)
    );

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Entered at the falling edge of cycle 1 (first START cycle); leaves at cycle 45 (done cycle).
    task automatic check_frame(input logic [10:0] fe, input logic [10:0] fo,
                               input logic pe, input logic po, input int poke);
        for (int c = 1; c <= 45; c++) begin
            if (c == poke) begin
                send    = 1'b1;
                data_in = 8'h00;
            end else if (c == poke + 1) begin
                send = 1'b0;
            end
            if (c <= 44) begin
                int b;
                b = (c - 1) / 4;
                chk("frame_even", {8'h0, tx_e, busy_e, done_e}, {8'h0, fe[10 - b], 1'b1, 1'b0});
                chk("frame_odd",  {8'h0, tx_o, busy_o, done_o}, {8'h0, fo[10 - b], 1'b1, 1'b0});
            end else begin
                chk("done_even", {8'h0, tx_e, busy_e, done_e}, {8'h0, 3'b101});
                chk("done_odd",  {8'h0, tx_o, busy_o, done_o}, {8'h0, 3'b101});
                chk("parity_even", {10'h0, par_e}, {10'h0, pe});
                chk("parity_odd",  {10'h0, par_o}, {10'h0, po});
            end
            if (c < 45) @(negedge clk);
        end
    endtask

    task automatic check_idle(input string name);
        chk(name, {5'h0, tx_e, busy_e, done_e, tx_o, busy_o, done_o},
                  {5'h0, 3'b100, 3'b100});
    endtask

    initial begin
        vecs[0] = '{8'hA5, 11'b01010010101, 11'b01010010111, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 11'b01110000011, 11'b01110000001, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 11'b00011110001, 11'b00011110011, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 11'b00000000111, 11'b00000000101, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset_outputs");
        chk("reset_parity", {9'h0, par_e, par_o}, 11'h0);
        n_rst = 1'b1;

        // Single frames, data_in scrambled after acceptance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            send    = 1'b1;
            data_in = vecs[i].data;
            @(negedge clk);
            send    = 1'b0;
            data_in = ~vecs[i].data;
            check_frame(vecs[i].frame_even, vecs[i].frame_odd, vecs[i].par_even, vecs[i].par_odd, -1);
            @(negedge clk);
            check_idle("post_frame_idle");
            chk("parity_hold", {9'h0, par_e, par_o}, {9'h0, vecs[i].par_even, vecs[i].par_odd});
        end

        // Back-to-back: send held high, 0x00 then 0xFF
        @(negedge clk);
        send    = 1'b1;
        data_in = 8'h00;
        @(negedge clk);
        data_in = 8'hFF;
        check_frame(11'b00000000001, 11'b00000000011, 1'b0, 1'b1, -1);
        @(negedge clk);
        send = 1'b0;
        check_frame(11'b01111111101, 11'b01111111111, 1'b0, 1'b1, -1);
        @(negedge clk);
        check_idle("b2b_idle");

        // send pulsed during DATA bit 3 must be ignored
        @(negedge clk);
        send    = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        send = 1'b0;
        check_frame(vecs[0].frame_even, vecs[0].frame_odd, 1'b0, 1'b1, 18);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_idle("no_second_frame");
        end

        // Asynchronous reset in the middle of DATA
        @(negedge clk);
        send    = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        send = 1'b0;
        repeat (9) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_idle("async_reset");
        chk("async_reset_parity", {9'h0, par_e, par_o}, 11'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        n_rst = 1'b1;
        @(negedge clk);
        check_idle("after_release");

        // New frame after reset
        send    = 1'b1;
        data_in = vecs[1].data;
        @(negedge clk);
        send    = 1'b0;
        data_in = 8'hAA;
        check_frame(vecs[1].frame_even, vecs[1].frame_odd, vecs[1].par_even, vecs[1].par_odd, -1);
        @(negedge clk);
        check_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
